// File: rtl/sm_node_sequencer.sv
// Route sequencer: steps through a preloaded list of turn codes and feeds the
// line-follower controller one node command at a time, handshaking on r_node_detected.
module sm_node_sequencer #(
    parameter int unsigned DEPTH     = 21,
    parameter int unsigned END_NODE  = 22,
    parameter int unsigned MIN_PULSE = 2,
    parameter int unsigned HOLDOFF   = 5000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] path_len,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [1:0] wr_data,
    input  logic       r_node_detected,
    output logic [5:0] node,
    output logic       left,
    output logic       right,
    output logic       reverse,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_NODE,
        S_TURNING,
        S_DONE
    } state_e;

    localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int unsigned PW = $clog2(MIN_PULSE + 1);

    localparam logic [5:0]    DEPTH_L = 6'(DEPTH);
    localparam logic [5:0]    END_L   = 6'(END_NODE);
    localparam logic [HW-1:0] HOLD_L  = HW'(HOLDOFF);
    localparam logic [PW-1:0] PULSE_L = PW'(MIN_PULSE);

    state_e        state_q, state_d;
    logic [1:0]    mem_q [DEPTH];
    logic [4:0]    idx_q, idx_d;
    logic [5:0]    len_q, len_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic [5:0]    node_q, node_d;

    logic [5:0]    idx_inc;
    logic [5:0]    len_start;
    logic          wr_ok;

    assign idx_inc   = {1'b0, idx_q} + 6'd1;
    assign len_start = (path_len > DEPTH_L) ? DEPTH_L : path_len;
    assign wr_ok     = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_L);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cmd_d   = cmd_q;
        hold_d  = hold_q;
        pulse_d = pulse_q;
        node_d  = node_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d   = len_start;
                    idx_d   = '0;
                    hold_d  = '0;
                    pulse_d = '0;
                    if (len_start == 6'd0) begin
                        state_d = S_DONE;
                        node_d  = END_L;
                        cmd_d   = '0;
                    end else begin
                        state_d = S_WAIT_NODE;
                        node_d  = '0;
                        cmd_d   = mem_q[0];
                    end
                end
            end
            S_WAIT_NODE: begin
                if (hold_q != '0) begin
                    hold_d  = hold_q - HW'(1);
                    pulse_d = '0;
                end else if (r_node_detected) begin
                    if (pulse_q + PW'(1) == PULSE_L) begin
                        state_d = S_TURNING;
                        pulse_d = '0;
                    end else begin
                        pulse_d = pulse_q + PW'(1);
                    end
                end else begin
                    pulse_d = '0;
                end
            end
            S_TURNING: begin
                if (!r_node_detected) begin
                    if (idx_inc == len_q) begin
                        state_d = S_DONE;
                        node_d  = END_L;
                        cmd_d   = '0;
                    end else begin
                        state_d = S_WAIT_NODE;
                        idx_d   = idx_inc[4:0];
                        node_d  = idx_inc;
                        cmd_d   = mem_q[idx_inc[4:0]];
                        hold_d  = HOLD_L;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort wins over everything, including a start in the same cycle
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cmd_d   = '0;
            hold_d  = '0;
            pulse_d = '0;
            node_d  = '0;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cmd_q   <= '0;
            hold_q  <= '0;
            pulse_q <= '0;
            node_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cmd_q   <= cmd_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
            node_q  <= node_d;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign node    = node_q;
    assign left    = (cmd_q == 2'b01);
    assign right   = (cmd_q == 2'b10);
    assign reverse = (cmd_q == 2'b11);
    assign busy    = (state_q == S_WAIT_NODE) || (state_q == S_TURNING);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_sm_node_sequencer.sv
// Directed bench for sm_node_sequencer: route stepping, pulse filtering, holdoff,
// length clamping, abort/start priority, write lockout and async reset.
module tb_sm_node_sequencer;

    localparam int unsigned HOLD = 50;

    localparam logic [2:0] C_S = 3'b000;
    localparam logic [2:0] C_L = 3'b100;
    localparam logic [2:0] C_R = 3'b010;
    localparam logic [2:0] C_V = 3'b001;

    logic       clk_50;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [5:0] path_len;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [1:0] wr_data;
    logic       r_node_detected;
    logic [5:0] node;
    logic       left;
    logic       right;
    logic       reverse;
    logic       busy;
    logic       done;

    int vectors;
    int miscompares;

    sm_node_sequencer #(
        .DEPTH    (21),
        .END_NODE (22),
        .MIN_PULSE(2),
        .HOLDOFF  (HOLD)
    ) dut (
        .clk_50         (clk_50),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .path_len       (path_len),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .r_node_detected(r_node_detected),
        .node           (node),
        .left           (left),
        .right          (right),
        .reverse        (reverse),
        .busy           (busy),
        .done           (done)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [5:0] en, input logic [2:0] ecmd,
                              input logic eb, input logic ed);
        logic [10:0] obs;
        logic [10:0] exp;
        obs = {node, left, right, reverse, busy, done};
        exp = {en, ecmd, eb, ed};
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed node=%0d lrv=%b busy=%b done=%b expected node=%0d lrv=%b busy=%b done=%b",
                   tag, obs[10:5], obs[4:2], obs[1], obs[0], exp[10:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic run(input logic [5:0] len);
        path_len = len; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse(input int n);
        r_node_detected = 1'b1;
        tick(n);
        r_node_detected = 1'b0;
        tick(1);
    endtask

    function automatic logic [2:0] route_cmd(input int j);
        case (j)
            0: return C_L;
            1: return C_R;
            2: return C_S;
            3: return C_V;
            default: return C_S;
        endcase
    endfunction

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; path_len = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; r_node_detected = 1'b0;

        #3;
        expect_out("reset_state", 6'd0, C_S, 1'b0, 1'b0);
        @(posedge clk_50); @(posedge clk_50); #1;
        rst_n = 1'b1;
        tick(1);

        // Basic four-node route
        wr(5'd0, 2'b01); wr(5'd1, 2'b10); wr(5'd2, 2'b00); wr(5'd3, 2'b11);
        run(6'd4);
        expect_out("run_start", 6'd0, C_L, 1'b1, 1'b0);
        r_node_detected = 1'b1;
        tick(20);
        expect_out("turn_hold", 6'd0, C_L, 1'b1, 1'b0);
        r_node_detected = 1'b0;
        tick(1);
        expect_out("node1", 6'd1, C_R, 1'b1, 1'b0);
        tick(60); pulse(20);
        expect_out("node2", 6'd2, C_S, 1'b1, 1'b0);
        tick(60); pulse(20);
        expect_out("node3", 6'd3, C_V, 1'b1, 1'b0);
        tick(60); pulse(20);
        expect_out("route_done", 6'd22, C_S, 1'b0, 1'b1);

        // Glitch filtering, then a minimum-length pulse
        run(6'd4);
        expect_out("rerun_start", 6'd0, C_L, 1'b1, 1'b0);
        pulse(1);
        tick(3);
        expect_out("glitch_ignored", 6'd0, C_L, 1'b1, 1'b0);
        r_node_detected = 1'b1;
        tick(2);
        expect_out("min_pulse_turning", 6'd0, C_L, 1'b1, 1'b0);
        r_node_detected = 1'b0;
        tick(1);
        expect_out("min_pulse_advance", 6'd1, C_R, 1'b1, 1'b0);

        // Holdoff window
        tick(10);
        pulse(20);
        expect_out("holdoff_ignored", 6'd1, C_R, 1'b1, 1'b0);
        tick(30);
        pulse(3);
        expect_out("after_holdoff", 6'd2, C_S, 1'b1, 1'b0);

        // Abort while turning
        tick(60);
        r_node_detected = 1'b1;
        tick(3);
        abort = 1'b1; r_node_detected = 1'b0;
        tick(1);
        abort = 1'b0;
        expect_out("abort_turning", 6'd0, C_S, 1'b0, 1'b0);

        // Abort beats start
        path_len = 6'd4; start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        expect_out("start_abort", 6'd0, C_S, 1'b0, 1'b0);
        tick(3);
        expect_out("start_abort_idle", 6'd0, C_S, 1'b0, 1'b0);

        // Writes during a run are dropped
        run(6'd1);
        expect_out("len1_start", 6'd0, C_L, 1'b1, 1'b0);
        wr(5'd0, 2'b10);
        pulse(3);
        expect_out("len1_done", 6'd22, C_S, 1'b0, 1'b1);
        run(6'd1);
        expect_out("busy_write_dropped", 6'd0, C_L, 1'b1, 1'b0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;

        // Zero-length route
        run(6'd0);
        expect_out("len0_done", 6'd22, C_S, 1'b0, 1'b1);

        // Length clamped to DEPTH
        run(6'd40);
        expect_out("clamp_start", 6'd0, C_L, 1'b1, 1'b0);
        for (int i = 0; i < 21; i++) begin
            pulse(3);
            if (i < 20) begin
                expect_out($sformatf("clamp_node%0d", i + 1), 6'(i + 1), route_cmd(i + 1), 1'b1, 1'b0);
            end else begin
                expect_out("clamp_end", 6'd22, C_S, 1'b0, 1'b1);
            end
            tick(55);
        end

        // Async reset mid-run clears outputs and memory
        run(6'd4);
        pulse(3);
        expect_out("pre_reset", 6'd1, C_R, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 6'd0, C_S, 1'b0, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        expect_out("post_reset_idle", 6'd0, C_S, 1'b0, 1'b0);
        run(6'd1);
        expect_out("mem_cleared", 6'd0, C_S, 1'b1, 1'b0);
        pulse(3);
        expect_out("mem_cleared_done", 6'd22, C_S, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sm_node_sequencer.md
# sm_node_sequencer

Path sequencer that issues per-node turn commands to the line-follower controller and tracks its progress along a preloaded route. It sits upstream of the robot control block. It drives the controller's `node`, `left`, `right` and `reverse` inputs, and consumes the controller's `r_node_detected` stop/turn flag as its "node reached / turn in progress" handshake. When the route is exhausted it presents `END_NODE` on `node`, which makes the controller halt.

## Interface
- `DEPTH`, default 21: route memory entries. Must be less than `END_NODE`.
- `END_NODE`, default 22: node code that commands the controller to stop.
- `MIN_PULSE`, default 2: consecutive high cycles of `r_node_detected` needed to accept a node.
- `HOLDOFF`, default 5000: cycles after a turn completes during which `r_node_detected` is ignored.

Ports:
- `clk_50` input 1: system clock. One clock domain only.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle run request.
- `abort` input 1: single-cycle cancel.
- `path_len` input 6: number of route entries to execute, sampled on an accepted `start`.
- `wr_en` input 1: route memory write strobe.
- `wr_addr` input 5: route memory address. Values ≥ `DEPTH` are ignored.
- `wr_data` input 2: turn code. 00 = straight, 01 = left, 10 = right, 11 = reverse.
- `r_node_detected` input 1: controller node/turn flag.
- `node` output 6: current node index, or `END_NODE`.
- `left`, `right`, `reverse` output 1 each: decoded turn command. At most one is high.
- `busy` output 1: run in progress.
- `done` output 1: route complete, held until the next start or abort.

## Operation
- States:
  - IDLE
  - WAIT_NODE
  - TURNING
  - DONE
- Reset, async: state IDLE, all route entries 00, internal index 0, holdoff and pulse counters 0. Outputs on reset: `node`=0, `left`/`right`/`reverse`=0, `busy`=0, `done`=0.
- Route writes: accepted only when `busy`=0, i.e. in IDLE or DONE. Writes while busy are dropped.
- Command decode: `left`/`right`/`reverse` decode a registered `cmd` register, not memory directly. Code 00 drives all three low.
- IDLE, on `start`:
  - Latch `len` = min(`path_len`, `DEPTH`).
  - If `len`=0, go to DONE.
  - Otherwise set index=0, `cmd`=mem[0], holdoff=0, and go to WAIT_NODE.
- WAIT_NODE:
  - While holdoff > 0, decrement holdoff and keep the pulse counter at 0.
  - Otherwise count consecutive cycles with `r_node_detected`=1. The counter clears whenever the input is 0.
  - When the count reaches `MIN_PULSE`, go to TURNING. `cmd` and `node` are held.
- TURNING: on the first cycle with `r_node_detected`=0:
  - index+1 == `len`: go to DONE.
  - Otherwise index ← index+1, `cmd` ← mem[index+1], holdoff ← `HOLDOFF`, back to WAIT_NODE.
- DONE:
  - `node`=`END_NODE`, `cmd`=00, `done`=1, `busy`=0.
  - `start` re-runs the route exactly as from IDLE. Memory is preserved.
- `abort`, in any state: go to IDLE and clear `cmd`, `node`, `done`, and the counters. Memory is preserved.
- Priority: `abort` over `start`. `start` is ignored while `busy`=1.
- Arithmetic: index is 5 bits and never exceeds `DEPTH`-1, so `node` never aliases `END_NODE` during a run. `len` clamping is an unsigned compare.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- `start` accepted at edge N:
  - Cycle N+1 shows `busy`=1, `node`=0, and the mem[0] command.
  - With `len`=0, `done`=1 at N+1 instead.
- Node acceptance: `r_node_detected` high at edges K..K+`MIN_PULSE`-1 gives state TURNING after edge K+`MIN_PULSE`-1.
- Turn completion: `r_node_detected` low at edge F updates `node`/`cmd` (or enters DONE) visible in cycle F+1. Holdoff covers the `HOLDOFF` cycles after F+1.
- A glitch shorter than `MIN_PULSE` in WAIT_NODE causes no state change.
- `abort` at edge A: all outputs read their reset values in cycle A+1.
- Async reset mid-run: outputs go to reset values immediately, without waiting for a clock edge. Route memory is also cleared.

## Test plan
- Load route {01,10,00,11}, `path_len`=4, `start`. Then four pulses of `r_node_detected`, each 20 cycles high, spaced beyond `HOLDOFF` → `node` steps 0,1,2,3 with `left` → `right` → none → `reverse`. After the fourth pulse falls: `node`=22, `done`=1, `busy`=0.
- In WAIT_NODE, apply a 1-cycle `r_node_detected` pulse with `MIN_PULSE`=2 → no advance. A 2-cycle pulse → TURNING, and the advance happens when the input falls.
- `r_node_detected` re-asserted 10 cycles after a turn completes, inside `HOLDOFF` → ignored, `node` unchanged. Asserted after `HOLDOFF` expires → accepted.
- `path_len`=40 → clamped to 21: 21 nodes accepted, then `node`=22. `path_len`=0 → `done`=1 one cycle after `start`.
- `start` and `abort` in the same cycle → stays IDLE. `abort` mid-TURNING → next cycle `node`=0, commands 0, `busy`=0. A memory write during the run is ignored, confirmed by read-back through the next run.
- `rst_n` pulsed low mid-run, between clock edges → outputs clear asynchronously. After release, a run with `path_len`=1 shows straight (all commands 0) because memory is reset to 00.
